// File: rtl/vram_paint_controller.sv
// vram_paint_controller
// The only writer to the VRAM write port. After reset, or when clear_req is
// seen while idle or painting, it fills the whole framebuffer with
// clear_color. While idle it serves the touch channels round-robin. For each
// valid touch it stamps a square brush of half-size r around the touch point
// and clips the brush to the display.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   clear_req     one-cycle full-screen fill request
//   clear_color   fill colour, sampled when a clear starts
//   touch_valid   per-channel touch present
//   touch_x/y     packed per-channel coordinates
//   pen_color     packed per-channel stroke colour
//   brush_r       brush half-size, saturated to BRUSH_MAX
//   vram_wr_*     registered VRAM write strobe/address/data
//   clearing      high while filling
//   busy          high while filling or stamping
module vram_paint_controller #(
  parameter int unsigned DISPLAY_WIDTH  = 240,
  parameter int unsigned DISPLAY_HEIGHT = 320,
  parameter int unsigned VRAM_W         = 16,
  parameter int unsigned N_TOUCH        = 2,
  parameter int unsigned BRUSH_MAX      = 7,
  parameter int unsigned L              = DISPLAY_WIDTH * DISPLAY_HEIGHT,
  parameter int unsigned AW             = $clog2(L),
  parameter int unsigned XW             = $clog2(DISPLAY_WIDTH),
  parameter int unsigned YW             = $clog2(DISPLAY_HEIGHT),
  parameter int unsigned RW             = $clog2(BRUSH_MAX + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_req,
  input  logic [VRAM_W-1:0]           clear_color,
  input  logic [N_TOUCH-1:0]          touch_valid,
  input  logic [N_TOUCH*XW-1:0]       touch_x,
  input  logic [N_TOUCH*YW-1:0]       touch_y,
  input  logic [N_TOUCH*VRAM_W-1:0]   pen_color,
  input  logic [RW-1:0]               brush_r,
  output logic                        vram_wr_ena,
  output logic [AW-1:0]               vram_wr_addr,
  output logic [VRAM_W-1:0]           vram_wr_data,
  output logic                        clearing,
  output logic                        busy
);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_PAINT = 2'd2;

  localparam int unsigned CW  = (N_TOUCH > 1) ? $clog2(N_TOUCH) : 1;
  // The signed scan width must hold coordinate +/- r without overflow, even
  // when the brush is larger than the display.
  localparam int unsigned MW0 = (XW > YW) ? XW : YW;
  localparam int unsigned MW  = (MW0 > RW) ? MW0 : RW;
  localparam int unsigned SW  = MW + 2;

  logic [1:0]               state_q, state_d;
  logic [AW-1:0]            clr_cnt_q, clr_cnt_d;
  logic [VRAM_W-1:0]        clr_color_q, clr_color_d;
  logic [CW-1:0]            rr_q, rr_d;
  logic [CW-1:0]            ch_q, ch_d;
  logic [XW-1:0]            cx_q, cx_d;
  logic [YW-1:0]            cy_q, cy_d;
  logic [VRAM_W-1:0]        pen_q, pen_d;
  logic [RW-1:0]            r_q, r_d;
  logic signed [SW-1:0]     dx_q, dx_d;
  logic signed [SW-1:0]     dy_q, dy_d;
  logic                     wr_ena_q, wr_ena_d;
  logic [AW-1:0]            wr_addr_q, wr_addr_d;
  logic [VRAM_W-1:0]        wr_data_q, wr_data_d;

  logic [RW-1:0]            r_sat;
  logic signed [SW-1:0]     r_sat_ext, r_ext;
  logic signed [SW-1:0]     px, py;
  logic [SW-1:0]            px_u, py_u;
  logic                     in_bounds;
  logic [AW-1:0]            paint_addr;
  logic                     hit;
  logic [CW-1:0]            hit_ch;

  assign r_sat     = (32'(brush_r) > BRUSH_MAX) ? RW'(BRUSH_MAX) : brush_r;
  assign r_sat_ext = $signed({{(SW - RW){1'b0}}, r_sat});
  assign r_ext     = $signed({{(SW - RW){1'b0}}, r_q});

  assign px   = $signed({{(SW - XW){1'b0}}, cx_q}) + dx_q;
  assign py   = $signed({{(SW - YW){1'b0}}, cy_q}) + dy_q;
  assign px_u = px;
  assign py_u = py;

  // A negative sign bit or a value at/above the edge is clipped, never wrapped.
  assign in_bounds = !px[SW-1] && !py[SW-1] &&
                     ({{(32 - SW){1'b0}}, px_u} < DISPLAY_WIDTH) &&
                     ({{(32 - SW){1'b0}}, py_u} < DISPLAY_HEIGHT);

  assign paint_addr = AW'(py_u) * AW'(DISPLAY_WIDTH) + AW'(px_u);

  // First valid channel at or after the round-robin pointer.
  always_comb begin
    hit    = 1'b0;
    hit_ch = '0;
    for (int unsigned k = 0; k < N_TOUCH; k++) begin
      int unsigned j;
      j = (32'(rr_q) + k) % N_TOUCH;
      if (!hit && touch_valid[j]) begin
        hit    = 1'b1;
        hit_ch = CW'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    rr_d        = rr_q;
    ch_d        = ch_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    pen_d       = pen_q;
    r_d         = r_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    wr_ena_d    = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    case (state_q)
      S_CLEAR: begin
        // clear_req is deliberately ignored here.
        wr_ena_d  = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = clr_color_q;
        if (clr_cnt_q == AW'(L - 1)) begin
          state_d = S_IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end

      S_IDLE: begin
        if (clear_req) begin
          clr_color_d = clear_color;
          clr_cnt_d   = '0;
          state_d     = S_CLEAR;
        end else if (hit) begin
          ch_d    = hit_ch;
          cx_d    = touch_x[hit_ch*XW +: XW];
          cy_d    = touch_y[hit_ch*YW +: YW];
          pen_d   = pen_color[hit_ch*VRAM_W +: VRAM_W];
          r_d     = r_sat;
          dx_d    = -r_sat_ext;
          dy_d    = -r_sat_ext;
          state_d = S_PAINT;
        end
      end

      S_PAINT: begin
        if (clear_req) begin
          // Abort the stamp. No write this cycle, and the pointer is not advanced.
          clr_color_d = clear_color;
          clr_cnt_d   = '0;
          state_d     = S_CLEAR;
        end else begin
          wr_ena_d = in_bounds;
          if (in_bounds) begin
            wr_addr_d = paint_addr;
            wr_data_d = pen_q;
          end
          if (dx_q == r_ext) begin
            if (dy_q == r_ext) begin
              rr_d    = (32'(ch_q) == N_TOUCH - 1) ? '0 : ch_q + 1'b1;
              state_d = S_IDLE;
            end else begin
              dx_d = -r_ext;
              dy_d = dy_q + 1'b1;
            end
          end else begin
            dx_d = dx_q + 1'b1;
          end
        end
      end

      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_CLEAR;
      clr_cnt_q   <= '0;
      clr_color_q <= clear_color;
      rr_q        <= '0;
      ch_q        <= '0;
      cx_q        <= '0;
      cy_q        <= '0;
      pen_q       <= '0;
      r_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      wr_ena_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
      rr_q        <= rr_d;
      ch_q        <= ch_d;
      cx_q        <= cx_d;
      cy_q        <= cy_d;
      pen_q       <= pen_d;
      r_q         <= r_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      wr_ena_q    <= wr_ena_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign vram_wr_ena  = wr_ena_q;
  assign vram_wr_addr = wr_addr_q;
  assign vram_wr_data = wr_data_q;
  assign clearing     = (state_q == S_CLEAR);
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_vram_paint_controller.sv
// Scoreboard bench for vram_paint_controller on a 4x3 display. The stimulus
// pushes the expected VRAM writes, and a monitor pops and compares them.
module tb_vram_paint_controller;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int VW   = 16;
  localparam int N    = 2;
  localparam int BMAX = 5;
  localparam int XW   = 2;
  localparam int YW   = 2;
  localparam int AW   = 4;
  localparam int RW   = 3;
  localparam int L    = W * H;

  logic              clk = 1'b0;
  logic              rst;
  logic              clear_req;
  logic [VW-1:0]     clear_color;
  logic [N-1:0]      touch_valid;
  logic [N*XW-1:0]   touch_x;
  logic [N*YW-1:0]   touch_y;
  logic [N*VW-1:0]   pen_color;
  logic [RW-1:0]     brush_r;
  logic              vram_wr_ena;
  logic [AW-1:0]     vram_wr_addr;
  logic [VW-1:0]     vram_wr_data;
  logic              clearing;
  logic              busy;

  vram_paint_controller #(
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H),
    .VRAM_W        (VW),
    .N_TOUCH       (N),
    .BRUSH_MAX     (BMAX)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .touch_valid (touch_valid),
    .touch_x     (touch_x),
    .touch_y     (touch_y),
    .pen_color   (pen_color),
    .brush_r     (brush_r),
    .vram_wr_ena (vram_wr_ena),
    .vram_wr_addr(vram_wr_addr),
    .vram_wr_data(vram_wr_data),
    .clearing    (clearing),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int exp_a[$];
  int exp_d[$];
  int checks = 0;
  int errors = 0;
  int p_model = 0;   // round-robin pointer of the reference model

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: every presented write must match the head of the queue.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (vram_wr_ena !== 1'b0) begin
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write actual addr %0d data %h required none",
                   vram_wr_addr, vram_wr_data);
        end else begin
          int a, d;
          a = exp_a.pop_front();
          d = exp_d.pop_front();
          if (vram_wr_ena !== 1'b1 || int'(vram_wr_addr) != a || int'(vram_wr_data) != d) begin
            errors++;
            $display("FAIL write actual addr %0d data %h required addr %0d data %h",
                     vram_wr_addr, vram_wr_data, a, d[VW-1:0]);
          end
        end
      end
    end
  end

  task automatic push_clear(input int color, input int n);
    for (int i = 0; i < n; i++) begin
      exp_a.push_back(i);
      exp_d.push_back(color);
    end
  endtask

  // Reference stamp: raster over the square, skipping off-screen pixels.
  // Only the first `limit` scan positions are considered.
  task automatic push_stamp(input int cx, input int cy, input int r, input int pen,
                            input int limit);
    int pos;
    pos = 0;
    for (int dy = -r; dy <= r; dy++) begin
      for (int dx = -r; dx <= r; dx++) begin
        int px, py;
        px = cx + dx;
        py = cy + dy;
        if (pos < limit && px >= 0 && px < W && py >= 0 && py < H) begin
          exp_a.push_back(py * W + px);
          exp_d.push_back(pen);
        end
        pos++;
      end
    end
  endtask

  // Counts the negedges on which busy is still high. Called at a negedge.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    if (n >= 5000) begin
      errors++;
      checks++;
      $display("FAIL idle_timeout actual busy after %0d cycles required idle", n);
    end
  endtask

  // Starts a clear from idle. Optionally pulses clear_req again mid-clear;
  // that pulse must be ignored.
  task automatic do_clear(input int color, input int inject_at);
    int n;
    clear_color = VW'(color);
    clear_req   = 1'b1;
    push_clear(color, L);
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 5000) begin
      clear_req = (n == inject_at);
      if (n == inject_at) clear_color = ~VW'(color);
      n++;
      @(negedge clk);
    end
    clear_req = 1'b0;
    check("clear_cycles", n, L);
    check("clearing_low_after_clear", int'(clearing), 0);
  endtask

  // Holds a touch mask for nrep stamps, then releases it.
  task automatic run_stamps(input int mask, input int x0, input int y0, input int x1,
                            input int y1, input int pen0, input int pen1, input int rin,
                            input int nrep);
    int r, n, ch;
    r = (rin > BMAX) ? BMAX : rin;
    touch_x     = {XW'(x1), XW'(x0)};
    touch_y     = {YW'(y1), YW'(y0)};
    pen_color   = {VW'(pen1), VW'(pen0)};
    brush_r     = RW'(rin);
    touch_valid = N'(mask);
    if (mask == 0) begin
      repeat (3) begin
        @(negedge clk);
        check("idle_no_touch_busy", int'(busy), 0);
      end
      return;
    end
    for (int i = 0; i < nrep; i++) begin
      ch = mask[p_model] ? p_model : (p_model + 1) % N;
      if (ch == 0) push_stamp(x0, y0, r, pen0, 1 << 30);
      else         push_stamp(x1, y1, r, pen1, 1 << 30);
      @(posedge clk);
      @(negedge clk);
      if (i == nrep - 1) touch_valid = '0;
      // Inputs changing mid-stamp must not matter.
      touch_x = ~touch_x;
      touch_y = ~touch_y;
      wait_idle(n);
      touch_x = ~touch_x;
      touch_y = ~touch_y;
      check("stamp_cycles", n, (2 * r + 1) * (2 * r + 1));
      p_model = (ch + 1) % N;
    end
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    clear_req   = 1'b0;
    clear_color = 16'h0000;
    touch_valid = '0;
    touch_x     = '0;
    touch_y     = '0;
    pen_color   = '0;
    brush_r     = '0;

    // Reset state.
    @(posedge clk);
    #1;
    check("rst_clearing", int'(clearing), 1);
    check("rst_busy", int'(busy), 1);
    check("rst_wr_ena", int'(vram_wr_ena), 0);
    check("rst_wr_addr", int'(vram_wr_addr), 0);
    check("rst_wr_data", int'(vram_wr_data), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_clear(0, L);
    wait_idle(n);
    check("idle_clearing", int'(clearing), 0);
    check("idle_busy", int'(busy), 0);

    // Single pixel. The held touch stamps a second time.
    run_stamps(1, 2, 1, 0, 0, 16'hF800, 16'h0000, 0, 2);
    // Corner stamp, clipped to 4 of 9 positions.
    run_stamps(1, 0, 0, 0, 0, 16'h1234, 16'h0000, 1, 1);
    // Both channels held; stamps alternate between them.
    run_stamps(3, 1, 0, 3, 2, 16'hAAAA, 16'h5555, 0, 4);
    // Oversized brush saturates to BRUSH_MAX.
    run_stamps(2, 0, 0, 1, 1, 16'h0000, 16'hBEEF, 7, 1);

    // Abort an r=2 stamp on its third cycle.
    touch_x     = {XW'(0), XW'(2)};
    touch_y     = {YW'(0), YW'(2)};
    pen_color   = {16'h0000, 16'h07E0};
    brush_r     = 3'd2;
    touch_valid = 2'b01;
    push_stamp(2, 2, 2, 16'h07E0, 2);
    push_clear(16'h001F, L);
    @(posedge clk);
    @(negedge clk);
    touch_valid = '0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    clear_req   = 1'b1;
    clear_color = 16'h001F;
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    wait_idle(n);
    check("abort_clear_cycles", n, L);

    // A clear_req during a clear is ignored.
    do_clear(16'hC0DE, 4);

    // Reset in the middle of a clear restarts the fill from address 0.
    clear_color = 16'h7777;
    clear_req   = 1'b1;
    push_clear(16'h7777, 6);
    @(posedge clk);
    @(negedge clk);
    clear_req = 1'b0;
    n = 0;
    while (!(vram_wr_ena === 1'b1 && vram_wr_addr == 4'd5) && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("mid_clear_addr5_seen", int'(n < 100), 1);
    rst         = 1'b1;
    clear_color = 16'h4242;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_wr_ena", int'(vram_wr_ena), 0);
    end
    rst     = 1'b0;
    p_model = 0;
    push_clear(16'h4242, L);
    wait_idle(n);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op == 0) begin
        do_clear($urandom_range(0, 16'hFFFF), $urandom_range(0, 20));
      end else begin
        run_stamps($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 16'hFFFF),
                   $urandom_range(0, 16'hFFFF), $urandom_range(0, 7), $urandom_range(1, 3));
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_a.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual running required finished");
    $fatal(1);
  end

endmodule
